// File: rtl/noc_vc_pipeline_link.sv
// noc_vc_pipeline_link
// Router-to-router link stage. It retimes the forward flit path
// (data, dest, is_tail, vc, send) and the backward per-VC credit path by
// NUM_PIPELINE register stages each. With NUM_PIPELINE=0 both paths are
// plain wires.
//
// An optional per-VC credit monitor is built when the macro
// NOC_LINK_CREDIT_MONITOR_EN is defined. It keeps the upstream view of the
// credits for each VC and sets sticky underflow/overflow flags. When the
// macro is undefined, credit_count reads FLIT_BUFFER_DEPTH on every VC, the
// error flags stay at 0 and err_clear has no effect.
//
// Ports:
//   clk_noc, rst_n          link clock, asynchronous active-low reset
//   data_in .. send_in      flit from the upstream router
//   data_out .. send_out    flit retimed by NUM_PIPELINE cycles
//   credit_in / credit_out  per-VC credits, downstream -> upstream, retimed
//   err_clear               synchronous clear of the sticky error flags
//   credit_count            upstream-view credit counter per VC, VC0 in LSBs
//   err_underflow           sticky: flit sent on a VC that had no credit
//   err_overflow            sticky: credit returned on a VC that was already full
module noc_vc_pipeline_link #(
    parameter int NUM_PIPELINE      = 1,
    parameter int NUM_VC            = 2,
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int VC_WIDTH          = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                           clk_noc,
    input  logic                           rst_n,
    input  logic [FLIT_WIDTH-1:0]          data_in,
    input  logic [DEST_WIDTH-1:0]          dest_in,
    input  logic                           is_tail_in,
    input  logic [VC_WIDTH-1:0]            vc_in,
    input  logic                           send_in,
    output logic [NUM_VC-1:0]              credit_out,
    output logic [FLIT_WIDTH-1:0]          data_out,
    output logic [DEST_WIDTH-1:0]          dest_out,
    output logic                           is_tail_out,
    output logic [VC_WIDTH-1:0]            vc_out,
    output logic                           send_out,
    input  logic [NUM_VC-1:0]              credit_in,
    input  logic                           err_clear,
    output logic [NUM_VC*CNT_WIDTH-1:0]    credit_count,
    output logic [NUM_VC-1:0]              err_underflow,
    output logic [NUM_VC-1:0]              err_overflow
);

    localparam int FWD_WIDTH = FLIT_WIDTH + DEST_WIDTH + 1 + VC_WIDTH + 1;

    logic [FWD_WIDTH-1:0] fwd_in;
    logic [FWD_WIDTH-1:0] fwd_out;

    // All flit fields travel as a single word. They are registered every
    // cycle whatever the value of send, and send alone marks a valid flit.
    assign fwd_in = {data_in, dest_in, is_tail_in, vc_in, send_in};
    assign {data_out, dest_out, is_tail_out, vc_out, send_out} = fwd_out;

    generate
        if (NUM_PIPELINE == 0) begin : g_wire
            assign fwd_out    = fwd_in;
            assign credit_out = credit_in;
        end else begin : g_pipe
            logic [FWD_WIDTH-1:0] fwd_pipe_reg  [NUM_PIPELINE];
            logic [NUM_VC-1:0]    cred_pipe_reg [NUM_PIPELINE];

            // Plain shift register with no stall. Reset drops everything in flight.
            always_ff @(posedge clk_noc or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NUM_PIPELINE; i++) begin
                        fwd_pipe_reg[i]  <= '0;
                        cred_pipe_reg[i] <= '0;
                    end
                end else begin
                    fwd_pipe_reg[0]  <= fwd_in;
                    cred_pipe_reg[0] <= credit_in;
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        fwd_pipe_reg[i]  <= fwd_pipe_reg[i-1];
                        cred_pipe_reg[i] <= cred_pipe_reg[i-1];
                    end
                end
            end

            assign fwd_out    = fwd_pipe_reg[NUM_PIPELINE-1];
            assign credit_out = cred_pipe_reg[NUM_PIPELINE-1];
        end
    endgenerate

`ifdef NOC_LINK_CREDIT_MONITOR_EN
    // A flit on a VC index the link does not carry is a protocol violation.
    // It is reported on underflow bit 0 and leaves every counter unchanged.
    logic bad_vc;
    assign bad_vc = send_in && (32'(vc_in) >= NUM_VC);

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_mon
            logic                 dec;
            logic                 inc;
            logic                 at_max;
            logic                 at_zero;
            logic                 ovf_set;
            logic                 unf_set;
            logic [CNT_WIDTH-1:0] count_reg;
            logic                 unf_reg;
            logic                 ovf_reg;

            // Credits are counted as they appear on credit_out, which is
            // when the upstream router sees them. A send and a credit in the
            // same cycle cancel out, so neither can raise an error.
            assign dec     = send_in && (vc_in == VC_WIDTH'(gi));
            assign inc     = credit_out[gi];
            assign at_max  = (count_reg == CNT_WIDTH'(FLIT_BUFFER_DEPTH));
            assign at_zero = (count_reg == '0);
            assign ovf_set = inc && !dec && at_max;
            assign unf_set = (dec && !inc && at_zero) || ((gi == 0) && bad_vc);

            always_ff @(posedge clk_noc or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= CNT_WIDTH'(FLIT_BUFFER_DEPTH);
                    unf_reg   <= 1'b0;
                    ovf_reg   <= 1'b0;
                end else begin
                    if (inc && !dec && !at_max) begin
                        count_reg <= count_reg + CNT_WIDTH'(1);
                    end else if (dec && !inc && !at_zero) begin
                        count_reg <= count_reg - CNT_WIDTH'(1);
                    end
                    // If a clear and a new violation arrive in the same
                    // cycle, the violation wins.
                    unf_reg <= (unf_reg && !err_clear) || unf_set;
                    ovf_reg <= (ovf_reg && !err_clear) || ovf_set;
                end
            end

            assign credit_count[gi*CNT_WIDTH +: CNT_WIDTH] = count_reg;
            assign err_underflow[gi] = unf_reg;
            assign err_overflow[gi]  = ovf_reg;
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_mon_off
            assign credit_count[gi*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(FLIT_BUFFER_DEPTH);
        end
    endgenerate
    assign err_underflow = '0;
    assign err_overflow  = '0;

    logic unused_err_clear;
    assign unused_err_clear = &{1'b0, err_clear};
`endif

endmodule
